// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
// Shared definitions for the instruction fetch stage: datapath widths, the
// reset level, instruction-cache geometry, fetch FSM state encodings and a
// byte-lane insert helper used to assemble 32-bit words from byte reads.
package inst_fetch_pkg;

    localparam int AddrLen      = 32;
    localparam int InstLen      = 32;
    localparam logic [InstLen-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic ResetEnable = 1'b1;

    localparam int ICacheIdxLen = 4;
    localparam int ICacheTagLen = 26;
    localparam int ICacheDepth  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_e;

    // Returns word with byte lane idx replaced by data (lane 0 = bits 7:0).
    function automatic logic [InstLen-1:0] insert_byte(
        input logic [InstLen-1:0] word,
        input logic [1:0]         idx,
        input logic [7:0]         data
    );
        logic [InstLen-1:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// icache
// Direct-mapped instruction store, 16 entries of {valid, tag, 32-bit word}.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valids)
//   i_rd_idx, i_rd_tag  lookup address; o_hit / o_data answer combinationally
//   i_we, i_wr_idx,     line fill: tag and data written, entry marked valid
//   i_wr_tag, i_wr_data
module icache
    import inst_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ICacheIdxLen-1:0] i_rd_idx,
    input  logic [ICacheTagLen-1:0] i_rd_tag,
    output logic                    o_hit,
    output logic [InstLen-1:0]      o_data,
    input  logic                    i_we,
    input  logic [ICacheIdxLen-1:0] i_wr_idx,
    input  logic [ICacheTagLen-1:0] i_wr_tag,
    input  logic [InstLen-1:0]      i_wr_data
);

    logic [ICacheDepth-1:0]  r_valid;
    logic [ICacheTagLen-1:0] r_tag  [ICacheDepth];
    logic [InstLen-1:0]      r_data [ICacheDepth];

    // Valid bits: cleared on reset, set by a line fill.
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            r_valid <= {ICacheDepth{1'b0}};
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_data = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
// Instruction fetch stage. Holds the PC, looks it up in a direct-mapped
// icache and, on a miss, refills the line one byte at a time from a byte-wide
// memory port (one outstanding read at most), then delivers it as a hit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               ctrl stall vector; bit 0 holds the PC
//   jump_en, jump_target     redirect from EX (pulse), overrides stall
//   if_pc, if_inst           PC and instruction presented to IF/ID
//   if_stall_req             high while if_inst is not available
//   mem_req, mem_addr        byte read request (registered)
//   mem_ready                request accepted when mem_req & mem_ready
//   mem_rvalid, mem_rdata    returned byte
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic               jump_en,
    input  logic [AddrLen-1:0] jump_target,
    output logic [AddrLen-1:0] if_pc,
    output logic [InstLen-1:0] if_inst,
    output logic               if_stall_req,
    output logic               mem_req,
    output logic [AddrLen-1:0] mem_addr,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [7:0]         mem_rdata
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [AddrLen-1:0] r_pc;
    logic [AddrLen-1:0] w_pc_next;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_next;
    logic [1:0]         w_cnt_inc;
    logic [InstLen-1:0] r_word;
    logic [InstLen-1:0] w_word_next;
    logic               r_mem_req;
    logic               w_mem_req_next;
    logic [AddrLen-1:0] r_mem_addr;
    logic [AddrLen-1:0] w_mem_addr_next;
    logic               w_hit;
    logic [InstLen-1:0] w_cache_data;
    logic               w_cache_we;
    logic [InstLen-1:0] w_cache_wdata;
    logic               w_deliver;
    logic               w_unused_stall;

    // The PC register itself is the IF/ID PC, so stall[5:1] has no effect here.
    assign w_unused_stall = ^stall[5:1];

    icache u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (r_pc[5:2]),
        .i_rd_tag  (r_pc[31:6]),
        .o_hit     (w_hit),
        .o_data    (w_cache_data),
        .i_we      (w_cache_we),
        .i_wr_idx  (r_pc[5:2]),
        .i_wr_tag  (r_pc[31:6]),
        .i_wr_data (w_cache_wdata)
    );

    // Only an IDLE hit delivers; a hit seen while flushing must still stall.
    assign w_deliver    = (r_state == ST_IDLE) && w_hit;
    assign if_stall_req = !w_deliver;
    assign if_inst      = w_deliver ? w_cache_data : ZERO_WORD;
    assign if_pc        = r_pc;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign w_cnt_inc    = r_cnt + 2'd1;
    assign w_cache_wdata = insert_byte(r_word, r_cnt, mem_rdata);

    // PC next value: redirect beats stall, stall beats advance on delivery.
    always_comb begin
        w_pc_next = r_pc;
        if (jump_en) begin
            w_pc_next = jump_target;
        end else if (w_deliver && !stall[0]) begin
            w_pc_next = r_pc + 32'd4;
        end else begin
            w_pc_next = r_pc;
        end
    end

    // Fetch FSM next state, byte assembly and memory request generation.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_word_next     = r_word;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_cache_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!jump_en && !w_hit) begin
                    w_state_next    = ST_FETCH;
                    w_cnt_next      = 2'd0;
                    w_word_next     = ZERO_WORD;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = {r_pc[31:2], 2'b00};
                end else begin
                    w_mem_req_next  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (!r_mem_req) begin
                    // A read is outstanding: accepted, byte not yet returned.
                    if (jump_en && mem_rvalid) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = 2'd0;
                        w_word_next  = ZERO_WORD;
                    end else if (jump_en) begin
                        w_state_next = ST_FLUSH;
                        w_cnt_next   = 2'd0;
                        w_word_next  = ZERO_WORD;
                    end else if (mem_rvalid) begin
                        if (r_cnt == 2'd3) begin
                            w_cache_we   = 1'b1;
                            w_state_next = ST_IDLE;
                            w_cnt_next   = 2'd0;
                            w_word_next  = ZERO_WORD;
                        end else begin
                            w_word_next     = w_cache_wdata;
                            w_cnt_next      = w_cnt_inc;
                            w_mem_req_next  = 1'b1;
                            w_mem_addr_next = {r_pc[31:2], w_cnt_inc};
                        end
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end else begin
                    // Request pending; if it is accepted in the redirect cycle
                    // its byte is still coming and must be flushed.
                    if (jump_en) begin
                        w_mem_req_next = 1'b0;
                        w_cnt_next     = 2'd0;
                        w_word_next    = ZERO_WORD;
                        w_state_next   = mem_ready ? ST_FLUSH : ST_IDLE;
                    end else if (mem_ready) begin
                        w_mem_req_next = 1'b0;
                    end else begin
                        w_mem_req_next = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                w_mem_req_next = 1'b0;
                if (mem_rvalid) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_mem_req_next = 1'b0;
                w_cnt_next     = 2'd0;
            end
        endcase
    end

    // State, PC, assembly and memory-port registers.
    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            r_state    <= ST_IDLE;
            r_pc       <= ZERO_WORD;
            r_cnt      <= 2'd0;
            r_word     <= ZERO_WORD;
            r_mem_req  <= 1'b0;
            r_mem_addr <= ZERO_WORD;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_cnt      <= w_cnt_next;
            r_word     <= w_word_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
// Directed bench for inst_fetch: a byte-wide memory responder with adjustable
// latency, a table of warm-cache cycle vectors, and hand-written sequences for
// cold start, redirect flush, conflict miss, rvalid/jump collision and reset.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat   = 1;
    logic        pend      = 1'b0;
    int          pend_left = 0;
    logic [7:0]  pend_data = 8'h00;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_stall_req (if_stall_req),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[7:0] ^ 8'h5A, a[7:0] + 8'h11, 8'h13, a[7:0]};
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Memory responder: one outstanding read, returns after mem_lat cycles.
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (mem_req && mem_ready) begin
            if (mem_lat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem_byte(mem_addr);
            end else begin
                pend      <= 1'b1;
                pend_left <= mem_lat - 1;
                pend_data <= mem_byte(mem_addr);
            end
        end else if (pend) begin
            if (pend_left <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend_data;
                pend       <= 1'b0;
            end else begin
                pend_left <= pend_left - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tick until the current PC is delivered (pre-edge), bounded.
    task automatic wait_hit(input string name, input int budget);
        int n;
        n = 0;
        while (if_stall_req !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check32({name, "_hit_reached"}, {31'd0, if_stall_req}, 32'd0);
    endtask

    // Tick until a request for addr is presented (pre-edge), bounded.
    task automatic wait_req(input string name, input logic [31:0] addr, input int budget);
        int n;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === addr) && n < budget) begin
            tick();
            n++;
        end
        check32({name, "_req_seen"}, mem_addr, addr);
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        jump_en;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_sreq;
        logic        exp_mreq;
    } vec_t;

    vec_t vecs [9];

    int          req_cyc  [8];
    logic [31:0] req_addr [8];
    int          nreq;
    int          hit_cyc;
    int          nrv;

    initial begin
        // Warm-cache vectors, checked before each edge.
        vecs[0] = '{6'd0, 1'b1, 32'h0,  32'hC,  mem_word(32'hC),  1'b0, 1'b0};
        vecs[1] = '{6'd0, 1'b0, 32'h0,  32'h0,  mem_word(32'h0),  1'b0, 1'b0};
        vecs[2] = '{6'd0, 1'b0, 32'h0,  32'h4,  mem_word(32'h4),  1'b0, 1'b0};
        vecs[3] = '{6'd1, 1'b0, 32'h0,  32'h8,  mem_word(32'h8),  1'b0, 1'b0};
        vecs[4] = '{6'd1, 1'b0, 32'h0,  32'h8,  mem_word(32'h8),  1'b0, 1'b0};
        vecs[5] = '{6'd1, 1'b0, 32'h0,  32'h8,  mem_word(32'h8),  1'b0, 1'b0};
        vecs[6] = '{6'd0, 1'b0, 32'h0,  32'h8,  mem_word(32'h8),  1'b0, 1'b0};
        vecs[7] = '{6'd0, 1'b0, 32'h0,  32'hC,  mem_word(32'hC),  1'b0, 1'b0};
        vecs[8] = '{6'd0, 1'b0, 32'h0,  32'h10, 32'h0,            1'b1, 1'b0};

        rst = 1'b1; stall = 6'd0; jump_en = 1'b0; jump_target = 32'h0; mem_ready = 1'b1;
        tick();
        tick();
        check32("rst_pc",       if_pc,    32'h0);
        check32("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_stall_req", {31'd0, if_stall_req}, 32'd1);
        check32("rst_inst",     if_inst,  32'h0);

        // Cold start: cycle 0 is the first cycle with rst low.
        rst = 1'b0;
        nreq = 0;
        hit_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (mem_req === 1'b1 && mem_ready && nreq < 8) begin
                req_cyc[nreq]  = c;
                req_addr[nreq] = mem_addr;
                nreq++;
            end
            if (if_stall_req === 1'b0) begin
                hit_cyc = c;
                break;
            end
            tick();
        end
        check32("cold_nreq", 32'(nreq), 32'd4);
        for (int i = 0; i < 4 && i < nreq; i++) begin
            check32("cold_req_cycle", 32'(req_cyc[i]), 32'(2*i + 1));
            check32("cold_req_addr", req_addr[i], 32'(i));
        end
        check32("cold_hit_cycle", 32'(hit_cyc), 32'd9);
        check32("cold_inst", if_inst, 32'h0050_0093);
        check32("cold_pc",   if_pc,   32'h0);
        tick();
        check32("cold_pc_next", if_pc, 32'h4);

        for (int a = 4; a <= 12; a += 4) begin
            wait_hit("fill", 40);
            check32("fill_pc",   if_pc,   32'(a));
            check32("fill_inst", if_inst, mem_word(32'(a)));
            if (a != 12) tick();
        end

        // Warm loop, stall hold and move to a cold line.
        for (int i = 0; i < 9; i++) begin
            stall = vecs[i].stall;
            jump_en = vecs[i].jump_en;
            jump_target = vecs[i].target;
            #1;
            check32("vec_pc",   if_pc,   vecs[i].exp_pc);
            check32("vec_inst", if_inst, vecs[i].exp_inst);
            check32("vec_sreq", {31'd0, if_stall_req}, {31'd0, vecs[i].exp_sreq});
            check32("vec_mreq", {31'd0, mem_req},      {31'd0, vecs[i].exp_mreq});
            tick();
        end
        stall = 6'd0; jump_en = 1'b0;

        // Redirect with the byte-2 request of 0x10 outstanding.
        mem_lat = 3;
        wait_req("redir", 32'h12, 40);
        tick();
        jump_en = 1'b1; jump_target = 32'h40;
        tick();
        jump_en = 1'b0;
        check32("flush_pc",   if_pc, 32'h40);
        check32("flush_sreq", {31'd0, if_stall_req}, 32'd1);
        check32("flush_mreq", {31'd0, mem_req}, 32'd0);
        tick();
        check32("flush_mreq_hold", {31'd0, mem_req}, 32'd0);
        mem_lat = 1;
        wait_req("after_flush", 32'h40, 10);
        wait_hit("fill40", 40);
        check32("fill40_inst", if_inst, mem_word(32'h40));

        // Index 4 never written; abandon an unaccepted request; conflict miss.
        mem_ready = 1'b0;
        jump_en = 1'b1; jump_target = 32'h10;
        tick();
        jump_en = 1'b0;
        check32("idx4_invalid", {31'd0, if_stall_req}, 32'd1);
        tick();
        check32("idx4_req_addr", mem_addr, 32'h10);
        jump_en = 1'b1; jump_target = 32'h0;
        tick();
        jump_en = 1'b0;
        check32("abandon_pc",   if_pc, 32'h0);
        check32("abandon_mreq", {31'd0, mem_req}, 32'd0);
        check32("conflict_miss", {31'd0, if_stall_req}, 32'd1);
        mem_ready = 1'b1;
        tick();
        check32("refetch_mreq", {31'd0, mem_req}, 32'd1);
        check32("refetch_addr", mem_addr, 32'h0);
        wait_hit("refill0", 40);
        check32("refill0_inst", if_inst, 32'h0050_0093);

        // 4th byte arrives together with a redirect: no cache write.
        jump_en = 1'b1; jump_target = 32'h30;
        tick();
        jump_en = 1'b0;
        nrv = 0;
        for (int n = 0; n < 40; n++) begin
            if (mem_rvalid === 1'b1) nrv++;
            if (nrv == 4) break;
            tick();
        end
        check32("collide_nrv", 32'(nrv), 32'd4);
        jump_en = 1'b1; jump_target = 32'h30;
        tick();
        jump_en = 1'b0;
        check32("collide_no_write", {31'd0, if_stall_req}, 32'd1);
        check32("collide_inst", if_inst, 32'h0);
        wait_hit("fill30", 40);
        check32("fill30_inst", if_inst, mem_word(32'h30));

        // Reset with the byte-2 request of 0x20 outstanding.
        jump_en = 1'b1; jump_target = 32'h20;
        tick();
        jump_en = 1'b0;
        mem_lat = 4;
        wait_req("rstmid", 32'h22, 60);
        tick();
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check32("rstmid_pc",   if_pc, 32'h0);
        check32("rstmid_mreq", {31'd0, mem_req}, 32'd0);
        check32("rstmid_addr", mem_addr, 32'h0);
        repeat (5) tick();
        check32("rstmid_refetch_mreq", {31'd0, mem_req}, 32'd1);
        check32("rstmid_refetch_addr", mem_addr, 32'h0);
        mem_lat = 1;
        mem_ready = 1'b1;
        wait_hit("rstmid_fill", 40);
        check32("rstmid_inst", if_inst, 32'h0050_0093);
        check32("rstmid_hit_pc", if_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
